// File: rtl/chip_test_sequencer_if.sv
// Handshake bundle between the test sequencer, the front panel and a chip_74xx checker.
interface chip_test_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             Start;
    logic             Ack;
    logic             Done;
    logic             RSLT;
    logic             Run;
    logic             DISP_RSLT;
    logic             Busy;
    logic             Pass_LED;
    logic             Fail_LED;
    logic             Timeout;
    logic [CNT_W-1:0] Pass_Count;
    logic [CNT_W-1:0] Fail_Count;

    // Sequencer side
    modport master (
        input  Start, Ack, Done, RSLT,
        output Run, DISP_RSLT, Busy, Pass_LED, Fail_LED, Timeout, Pass_Count, Fail_Count
    );

    // Panel / checker side
    modport slave (
        output Start, Ack, Done, RSLT,
        input  Run, DISP_RSLT, Busy, Pass_LED, Fail_LED, Timeout, Pass_Count, Fail_Count
    );
endinterface

// File: rtl/chip_test_sequencer.sv
// Chip test sequencer: launches one checker run per Start press, waits for Done with a
// timeout, captures the settled result, releases the checker and shows pass/fail with
// saturating tallies.
module chip_test_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 8
) (
    input logic                   Clk,
    input logic                   Reset,
    chip_test_sequencer_if.master bus
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; it stops there, so it never wraps.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StSettle,
        StRelease,
        StShow
    } state_e;

    state_e           state_q, state_d;
    logic             start_prev_q, ack_prev_q;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             result_q, result_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    logic start_rise;
    logic ack_rise;

    assign start_rise = bus.Start & ~start_prev_q;
    assign ack_rise   = bus.Ack & ~ack_prev_q;

    // State, edge-detect, timeout counter, result and tally registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            start_prev_q <= 1'b0;
            ack_prev_q   <= 1'b0;
            tmo_cnt_q    <= '0;
            result_q     <= 1'b0;
            timeout_q    <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= bus.Start;
            ack_prev_q   <= bus.Ack;
            tmo_cnt_q    <= tmo_cnt_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    // Next-state logic for the run sequence and the tallies
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                tmo_cnt_d = '0;
                result_d  = 1'b0;
                timeout_d = 1'b0;
                state_d   = StWaitDone;
            end
            StWaitDone: begin
                // Done beats the timeout when both land on the final count
                if (bus.Done) begin
                    state_d = StSettle;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    result_d  = 1'b0;
                    state_d   = StRelease;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StSettle: begin
                // Checker's registered RSLT is valid the cycle after Done first rises
                result_d = bus.RSLT;
                state_d  = StRelease;
            end
            StRelease: begin
                state_d = StShow;
                if (result_q) begin
                    if (pass_cnt_q != '1) begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                end else begin
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                end
            end
            StShow: begin
                if (start_rise) begin
                    state_d = StLaunch;
                end else if (ack_rise) begin
                    result_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset drops them immediately
    assign bus.Run        = (state_q == StLaunch);
    assign bus.DISP_RSLT  = (state_q == StRelease);
    assign bus.Busy       = (state_q == StLaunch) || (state_q == StWaitDone) ||
                            (state_q == StSettle) || (state_q == StRelease);
    assign bus.Pass_LED   = (state_q == StShow) & result_q;
    assign bus.Fail_LED   = (state_q == StShow) & ~result_q;
    assign bus.Timeout    = (state_q == StShow) & timeout_q;
    assign bus.Pass_Count = pass_cnt_q;
    assign bus.Fail_Count = fail_cnt_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Directed bench for chip_test_sequencer with a small checker model driving Done/RSLT.
module tb_chip_test_sequencer;

    logic Clk = 1'b0;
    logic Reset;

    int n_cmp = 0;
    int n_err = 0;

    int runs, run_at, disps, disp_at;

    chip_test_sequencer_if #(.CNT_W(2)) bus ();

    chip_test_sequencer #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (2)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        bus.Done  = 1'b0;
        bus.RSLT  = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    // Caller has just raised Start. Cycle numbers count from the first tick.
    // done_dly < 0 means the checker never answers. restart_at > 0 re-raises Start mid-run.
    task automatic drive_run(input bit rslt, input int done_dly, input int restart_at,
                             output int n_runs, output int r_at,
                             output int n_disps, output int d_at);
        int cyc;
        cyc     = 0;
        n_runs  = 0;
        n_disps = 0;
        r_at    = -1;
        d_at    = -1;
        while (cyc < 80 && d_at < 0) begin
            tick();
            cyc++;
            if (bus.Run) begin
                n_runs++;
                r_at = cyc;
            end
            if (bus.DISP_RSLT) begin
                n_disps++;
                d_at = cyc;
            end
            if (restart_at > 0 && cyc == restart_at) bus.Start = 1'b0;
            if (restart_at > 0 && cyc == restart_at + 1) bus.Start = 1'b1;
            if (r_at >= 0 && done_dly >= 0 && cyc == r_at + done_dly) begin
                bus.Done = 1'b1;
                bus.RSLT = ~rslt;
            end
            if (r_at >= 0 && done_dly >= 0 && cyc == r_at + done_dly + 1) bus.RSLT = rslt;
            if (bus.DISP_RSLT) begin
                bus.Done = 1'b0;
                bus.RSLT = 1'b0;
            end
        end
        tick();
        if (bus.Run) n_runs++;
        if (bus.DISP_RSLT) n_disps++;
    endtask

    initial begin
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        bus.Done  = 1'b0;
        bus.RSLT  = 1'b0;
        tick();
        tick();
        check("rst_busy", bus.Busy, 0);
        check("rst_run", bus.Run, 0);
        check("rst_disp", bus.DISP_RSLT, 0);
        check("rst_leds", {bus.Pass_LED, bus.Fail_LED, bus.Timeout}, 0);
        check("rst_pass_cnt", bus.Pass_Count, 0);
        check("rst_fail_cnt", bus.Fail_Count, 0);
        Reset = 1'b0;
        tick();

        // 1: passing run, Done 9 cycles after Run
        bus.Start = 1'b1;
        drive_run(1'b1, 9, 0, runs, run_at, disps, disp_at);
        check("t1_run_at", run_at, 1);
        check("t1_run_width", runs, 1);
        check("t1_disp_at", disp_at, 12);
        check("t1_disp_count", disps, 1);
        check("t1_pass_led", bus.Pass_LED, 1);
        check("t1_fail_led", bus.Fail_LED, 0);
        check("t1_busy", bus.Busy, 0);
        check("t1_pass_cnt", bus.Pass_Count, 1);
        check("t1_fail_cnt", bus.Fail_Count, 0);

        // 2: failing run with Start held for 20 cycles
        do_reset();
        bus.Start = 1'b1;
        drive_run(1'b0, 9, 0, runs, run_at, disps, disp_at);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.Run) runs++;
        end
        check("t2_runs_held", runs, 1);
        check("t2_disp_at", disp_at, 12);
        check("t2_fail_led", bus.Fail_LED, 1);
        check("t2_pass_led", bus.Pass_LED, 0);
        check("t2_timeout", bus.Timeout, 0);
        check("t2_fail_cnt", bus.Fail_Count, 1);
        check("t2_pass_cnt", bus.Pass_Count, 0);

        // 3: timeout, 16 WAIT_DONE cycles after LAUNCH
        do_reset();
        bus.Start = 1'b1;
        drive_run(1'b1, -1, 0, runs, run_at, disps, disp_at);
        check("t3_run_at", run_at, 1);
        check("t3_disp_at", disp_at, 18);
        check("t3_disp_count", disps, 1);
        check("t3_fail_led", bus.Fail_LED, 1);
        check("t3_timeout", bus.Timeout, 1);
        check("t3_fail_cnt", bus.Fail_Count, 1);
        check("t3_pass_cnt", bus.Pass_Count, 0);

        // 4A: Done arrives on the final timeout cycle
        bus.Start = 1'b0;
        tick();
        bus.Start = 1'b1;
        drive_run(1'b1, 16, 0, runs, run_at, disps, disp_at);
        check("t4a_disp_at", disp_at, 19);
        check("t4a_timeout", bus.Timeout, 0);
        check("t4a_pass_led", bus.Pass_LED, 1);
        check("t4a_pass_cnt", bus.Pass_Count, 1);
        check("t4a_fail_cnt", bus.Fail_Count, 1);

        // 4B: second Start rise during WAIT_DONE is dropped
        bus.Start = 1'b0;
        tick();
        bus.Start = 1'b1;
        drive_run(1'b1, 9, 5, runs, run_at, disps, disp_at);
        check("t4b_runs", runs, 1);
        check("t4b_disp_at", disp_at, 12);
        check("t4b_pass_cnt", bus.Pass_Count, 2);

        // 4C: Start and Ack rise together in SHOW -> Start wins
        bus.Start = 1'b0;
        tick();
        check("t4c_show_hold", bus.Pass_LED, 1);
        bus.Start = 1'b1;
        bus.Ack   = 1'b1;
        drive_run(1'b0, 9, 0, runs, run_at, disps, disp_at);
        check("t4c_run_at", run_at, 1);
        check("t4c_fail_led", bus.Fail_LED, 1);
        check("t4c_fail_cnt", bus.Fail_Count, 2);

        // Ack alone in SHOW returns to IDLE; Ack in IDLE does nothing
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        tick();
        bus.Ack = 1'b1;
        tick();
        check("ack_leds", {bus.Pass_LED, bus.Fail_LED, bus.Timeout}, 0);
        check("ack_busy", bus.Busy, 0);
        bus.Ack = 1'b0;
        tick();
        bus.Ack = 1'b1;
        tick();
        check("ack_idle_run", bus.Run, 0);
        check("ack_idle_cnt", bus.Fail_Count, 2);
        bus.Ack = 1'b0;

        // 5: Pass_Count saturation at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.Start = 1'b0;
            tick();
            bus.Start = 1'b1;
            drive_run(1'b1, 9, 0, runs, run_at, disps, disp_at);
            check($sformatf("t5_pass_cnt_%0d", i), bus.Pass_Count, (i < 3) ? i + 1 : 3);
        end
        check("t5_fail_cnt", bus.Fail_Count, 0);

        // 6: asynchronous reset in WAIT_DONE
        bus.Start = 1'b0;
        tick();
        bus.Start = 1'b1;
        tick();
        check("t6_launch", bus.Run, 1);
        tick();
        tick();
        check("t6_wait_busy", bus.Busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        check("t6_async_busy", bus.Busy, 0);
        check("t6_async_pass_cnt", bus.Pass_Count, 0);
        check("t6_async_fail_cnt", bus.Fail_Count, 0);
        bus.Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        check("t6_idle", bus.Busy, 0);
        bus.Start = 1'b1;
        drive_run(1'b1, 9, 0, runs, run_at, disps, disp_at);
        check("t6_run_at", run_at, 1);
        check("t6_disp_at", disp_at, 12);
        check("t6_pass_led", bus.Pass_LED, 1);
        check("t6_pass_cnt", bus.Pass_Count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/chip_test_sequencer.md
Name: chip_test_sequencer

Overview:
- Initiator for the chip-checker handshake (Run / Done / RSLT / DISP_RSLT) used by every chip_74xx checker module.
- Turns a front-panel Start button into one checker run and waits for Done, with a timeout.
- Samples the settled RSLT, releases the checker with a DISP_RSLT pulse, then latches the pass/fail indication for display.
- Keeps saturating pass and fail tallies for the board's hex display.

Parameters:
TIMEOUT_CYCLES, 256, cycles allowed in WAIT_DONE before the run is declared a timeout failure (legal range 2..65535)
CNT_W, 8, width of Pass_Count and Fail_Count

Ports:
Clk  input  1  system clock, all state changes on rising edge
Reset  input  1  asynchronous, active-high; clears all state and outputs immediately
Start  input  1  synchronous level from the debounced button; the rising edge requests a test
Ack  input  1  synchronous level; the rising edge clears the displayed result
Done  input  1  from checker; high in the checker's last test cycle and while it holds its result
RSLT  input  1  from checker; registered pass(1)/fail(0); valid one cycle after Done first rises
Run  output  1  to checker; one-cycle launch pulse
DISP_RSLT  output  1  to checker; one-cycle release pulse
Busy  output  1  high in LAUNCH, WAIT_DONE, SETTLE, RELEASE
Pass_LED  output  1  high in SHOW when the captured result is pass
Fail_LED  output  1  high in SHOW when the captured result is fail or timeout
Timeout  output  1  high in SHOW when the run timed out
Pass_Count  output  CNT_W  number of passing runs, saturates at all-ones
Fail_Count  output  CNT_W  number of failing or timed-out runs, saturates at all-ones

Behaviour:
- Reset values: state IDLE. Run, DISP_RSLT, Busy, Pass_LED, Fail_LED and Timeout are 0. Counters are 0. Edge-detect registers and timeout counter are 0.
- Edge detect: one register each for Start and Ack; rise = level & ~prev. A Start held high generates only one request.
- IDLE:
  - Start rise goes to LAUNCH next cycle.
  - Ack is ignored.
- LAUNCH (1 cycle):
  - Run=1.
  - Timeout counter is cleared.
  - Always goes to WAIT_DONE.
- WAIT_DONE:
  - Run=0. The counter increments each cycle.
  - Done=1 goes to SETTLE. Done takes priority if Done is high on the same cycle the count reaches its limit.
  - Otherwise, when the count reaches TIMEOUT_CYCLES-1, set the internal timeout flag, record fail, and go to RELEASE.
  - Done is sampled only in this state. Done in LAUNCH/IDLE/SHOW is ignored.
- SETTLE (1 cycle):
  - Capture RSLT into the result register. The checker registers RSLT on the same edge that it enters its hold state.
  - Go to RELEASE.
- RELEASE (1 cycle):
  - DISP_RSLT=1. The checker returns to its halted state on this pulse. A pulse after a timeout is harmless.
  - Go to SHOW.
  - On this transition, increment Pass_Count if the result is pass, else Fail_Count. Each counter holds at 2^CNT_W-1.
- SHOW:
  - Pass_LED = result; Fail_LED = ~result; Timeout = timeout flag.
  - Start rise goes to LAUNCH (LEDs and flag clear on entry). Ack rise goes to IDLE (LEDs and flag clear).
  - Start and Ack rising together: Start wins.
- Start rise while Busy is ignored and not queued.
- Latency: Start rise sampled at edge k → Run high in cycle k+1 → DISP_RSLT exactly 2 cycles after the first Done-high cycle → LEDs valid the following cycle.
- Async Reset mid-run: all outputs drop to 0 at once. The next Start issues a fresh Run. The checker is reset by the same Reset.
- The timeout counter is wide enough for TIMEOUT_CYCLES-1 (16 bits max). It never wraps, because the count terminates at the limit.

Test Plan:
1. Passing run:
   - Stimulus: reset, then Start rise. The bench checker model asserts Done 9 cycles after Run, with RSLT=1 from the next cycle.
   - Required: Run is one cycle wide. DISP_RSLT is one pulse, 2 cycles after Done rises. Then Pass_LED=1, Fail_LED=0, Pass_Count=1, Fail_Count=0.
2. Failing run:
   - Stimulus: same as 1, but RSLT=0.
   - Required: Fail_LED=1, Timeout=0, Fail_Count=1. A Start held high for 20 cycles produces exactly one Run.
3. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, Done never asserted.
   - Required: after LAUNCH, exactly 16 cycles in WAIT_DONE, then DISP_RSLT pulse. Fail_LED=1, Timeout=1, Fail_Count=1.
4. Boundary and overlap:
   - Stimulus A: Done rises on the last timeout cycle. Required: goes to SETTLE, Timeout=0.
   - Stimulus B: Start rise during WAIT_DONE. Required: no second Run.
   - Stimulus C: Start and Ack rise together in SHOW. Required: goes to LAUNCH, Run pulses.
5. Saturation:
   - Stimulus: CNT_W=2, 5 passing runs.
   - Required: Pass_Count reads 1, 2, 3, 3, 3.
6. Reset mid-run:
   - Stimulus: assert Reset asynchronously mid-cycle during WAIT_DONE.
   - Required: Busy=0 and counters=0 before the next clock edge. After release, a Start rise gives a normal passing run.
